seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: q = a / b, r = a % b, for N-bit operands.
- Inverse arithmetic direction of the team's ripple-carry adder datapath. Each iteration does one trial subtraction, implemented as a ripple add of the inverted divisor with carry-in 1.
- Sits beside the adder/multiplier blocks in the arithmetic unit.
- Uses a start/busy/done handshake toward the controller.

---
 rtl/seq_divider_pkg.sv | 28 ++
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider_sub_stage.sv | 34 +++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// counter sizing and the full-adder cell used by the trial subtractor.
package seq_divider_pkg;

    localparam int DIV_N = 10;

    // Bits needed to count 0 .. n-1 iterations (n >= 2).
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

    localparam int CNT_W = cnt_w(DIV_N);

    // Quotient reported for a zero divisor at the default width.
    localparam logic [DIV_N-1:0] Q_ALL_ONES = '1;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_LOAD = 2'd1;
    localparam state_t S_RUN  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // One full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake plus operand and result buses between the
// arithmetic-unit controller (master) and the divider (slave).
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_sub_stage.sv
// W-bit trial subtractor a - b, built as a ripple of full-adder cells adding
// ~b with carry-in 1; no_borrow is the final carry-out.
module seq_divider_sub_stage
    import seq_divider_pkg::*;
#(
    parameter int W = DIV_N + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W-1:0] w_b_n;

    assign w_b_n = ~b;

    always_comb begin
        logic [1:0] fa;
        logic       carry;
        diff      = '0;
        fa        = '0;
        // NOTE: blocking assignments are deliberate here; carry ripples bit to
        // bit within one evaluation, which is exactly a combinational chain.
        carry     = 1'b1;
        for (int i = 0; i < W; i++) begin
            fa      = full_add(a[i], w_b_n[i], carry);
            diff[i] = fa[0];
            carry   = fa[1];
        end
        no_borrow = carry;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per RUN
// cycle, N cycles per quotient, with a start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_w(N);
    localparam logic [N-1:0] ONES = '1;

    state_t        r_state;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [N:0]    r_p;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;

    logic [N:0]    w_trial_a;
    logic [N:0]    w_trial_b;
    logic [N:0]    w_diff;
    logic          w_no_borrow;
    logic [N:0]    w_p_next;
    logic [N-1:0]  w_q_next;
    logic          w_last;
    logic          w_unused_p_msb;

    assign w_trial_a = {r_p[N-1:0], r_q[N-1]};
    assign w_trial_b = {1'b0, r_d};

    seq_divider_sub_stage #(.W(N + 1)) u_sub_stage (
        .a         (w_trial_a),
        .b         (w_trial_b),
        .diff      (w_diff),
        .no_borrow (w_no_borrow)
    );

    assign w_p_next = w_no_borrow ? w_diff : w_trial_a;
    assign w_q_next = {r_q[N-2:0], w_no_borrow};
    assign w_last   = (r_cnt == CW'(N - 1));

    // The partial remainder stays below the divisor, so its top bit is always 0
    // between iterations; only the trial subtraction needs the extra bit.
    assign w_unused_p_msb = r_p[N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_q     <= bus.dividend;
                        r_d     <= bus.divisor;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (r_d == '0) begin
                        r_quot  <= ONES;
                        r_rem   <= r_q;
                        r_dbz   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_p_next[N-1:0];
                        r_dbz   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status decodes straight from the state register so reset clears them at once.
    assign bus.busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at N = 10: results, latency,
// busy window, ignored starts, back-to-back starts and mid-operation reset.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int N      = 10;
    localparam int LAT    = N + 2;
    localparam int BUDGET = 40;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_divider_if #(.N(N)) bus_if ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start, let the next edge accept them, then scramble
    // the operand buses to show they are only sampled on the accepting edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        bus_if.dividend = a;
        bus_if.divisor  = b;
        bus_if.start    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start    = 1'b0;
        bus_if.dividend = ~a;
        bus_if.divisor  = ~b;
    endtask

    // Called 1 time unit after the accepting edge; lat counts edges from the
    // accepting edge (inclusive) to the edge after which done is seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = (bus_if.busy === 1'b1) ? 1 : 0;
        while (bus_if.done !== 1'b1 && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                                input logic exp_dbz);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (bus_if.quotient !== exp_q || bus_if.remainder !== exp_r || bus_if.div_by_zero !== exp_dbz) begin
            n_fail++;
            $display("FAIL %s result: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
                     name, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero, exp_q, exp_r, exp_dbz);
        end
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
        int lat, bc;
        @(negedge clk);
        start_op(a, b);
        wait_done(lat, bc);
        check_result(name, lat, (b == 0) ? 2 : LAT, exp_q, exp_r, (b == 0));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_if.busy, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
                     bus_if.busy, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        @(negedge clk);
        start_op(10'd1000, 10'd7);
        wait_done(lat, bc);
        check_result("basic_1000_7", lat, LAT, 10'd142, 10'd6, 1'b0);
        n_checks++;
        if (bc !== N + 1) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, N + 1);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.quotient !== 10'd142 || bus_if.remainder !== 10'd6) begin
            n_fail++;
            $display("FAIL basic_idle_hold: done=%b busy=%b q=%0d r=%0d, expected 0 0 142 6",
                     bus_if.done, bus_if.busy, bus_if.quotient, bus_if.remainder);
        end
    endtask

    task automatic test_boundaries();
        run_op("div_by_one",      10'd1023, 10'd1,    10'd1023, 10'd0);
        run_op("max_by_max",      10'd1023, 10'd1023, 10'd1,    10'd0);
        run_op("divisor_greater", 10'd5,    10'd9,    10'd0,    10'd5);
        run_op("zero_dividend",   10'd0,    10'd3,    10'd0,    10'd0);
    endtask

    task automatic test_div_by_zero();
        run_op("div_by_zero", 10'd77, 10'd0, Q_ALL_ONES, 10'd77);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        @(negedge clk);
        start_op(10'd100, 10'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_if.dividend = 10'd50;
        bus_if.divisor  = 10'd5;
        bus_if.start    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        lat = 4;
        while (bus_if.done !== 1'b1 && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_result("ignore_while_busy", lat, LAT, 10'd33, 10'd1, 1'b0);
        start_op(10'd50, 10'd5);
        n_checks++;
        if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_accept: done=%b busy=%b, expected 0 1", bus_if.done, bus_if.busy);
        end
        wait_done(lat, bc);
        check_result("back_to_back", lat, LAT, 10'd10, 10'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        start_op(10'd900, 10'd11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.busy, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
                     bus_if.busy, bus_if.done, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: activity after abort=%b, expected 0", saw_done);
        end
        run_op("after_reset_900_11", 10'd900, 10'd11, 10'd81, 10'd9);
    endtask

    task automatic test_random();
        int lat, bc, a, b, q, r;
        int bad_lat, bad_res;
        bad_lat = 0;
        bad_res = 0;
        for (int i = 0; i < 2000; i++) begin
            a = int'($urandom_range(0, 1023));
            b = (i % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
            @(negedge clk);
            start_op(N'(a), N'(b));
            wait_done(lat, bc);
            q = int'(bus_if.quotient);
            r = int'(bus_if.remainder);
            n_checks++;
            if (lat !== ((b == 0) ? 2 : LAT)) begin
                n_fail++;
                bad_lat++;
                if (bad_lat <= 5) $display("FAIL random_latency %0d/%0d: got %0d", a, b, lat);
            end
            n_checks++;
            if (b == 0) begin
                if (q !== 1023 || r !== a || bus_if.div_by_zero !== 1'b1) begin
                    n_fail++;
                    bad_res++;
                    if (bad_res <= 5) $display("FAIL random_dbz %0d/0: got q=%0d r=%0d dbz=%b, expected q=1023 r=%0d dbz=1",
                                               a, q, r, bus_if.div_by_zero, a);
                end
            end else if (q * b + r !== a || r >= b || bus_if.div_by_zero !== 1'b0) begin
                n_fail++;
                bad_res++;
                if (bad_res <= 5) $display("FAIL random_invariant %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d",
                                           a, b, q, r, bus_if.div_by_zero, a / b, a % b);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_div_by_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
